// File: rtl/fu_dispatch.sv
// fu_dispatch: routes issued packets into three per-functional-unit lane FIFOs.
// Each lane is an independent circular queue whose head entry is presented to
// its functional unit. Packets sent to select 3 are dropped and flagged. A flush
// empties every lane at once. dispatch_total counts packets delivered to the FUs.
module fu_dispatch #(
    parameter int PKT_W      = 64,
    parameter int LANE_DEPTH = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic [1:0]                          in_fu_sel,
    input  logic [PKT_W-1:0]                    in_pkt,
    output logic                                in_ready,
    input  logic                                flush,
    output logic [2:0]                          fu_valid,
    output logic [2:0][PKT_W-1:0]               fu_pkt,
    input  logic [2:0]                          fu_ready,
    output logic                                err_illegal,
    output logic [2:0][$clog2(LANE_DEPTH):0]    lane_count,
    output logic [15:0]                         dispatch_total
);

    localparam int PTR_W = $clog2(LANE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [2:0]  lane_full;
    logic [2:0]  lane_enq;
    logic [2:0]  lane_deq;
    logic        sel_full;
    logic        accept;
    logic        err_illegal_reg;
    logic        err_illegal_next;
    logic [15:0] dispatch_total_reg;
    logic [15:0] dispatch_total_next;

    // Fullness of the lane addressed by the incoming select; select 3 never blocks.
    always_comb begin
        sel_full = 1'b0;
        case (in_fu_sel)
            2'd0:    sel_full = lane_full[0];
            2'd1:    sel_full = lane_full[1];
            2'd2:    sel_full = lane_full[2];
            default: sel_full = 1'b0;
        endcase
    end

    // Ready depends only on lane state and the select, never on downstream ready.
    // It is held low during reset and flush so nothing is accepted then.
    assign in_ready = !reset && !flush && !sel_full;
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [PKT_W-1:0] mem_reg [LANE_DEPTH];
            logic [PTR_W-1:0] head_reg;
            logic [PTR_W-1:0] tail_reg;
            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;

            assign lane_full[gi]  = (count_reg == CNT_W'(LANE_DEPTH));
            assign lane_enq[gi]   = accept && (in_fu_sel == 2'(gi));
            assign fu_valid[gi]   = (count_reg != '0);
            assign lane_deq[gi]   = fu_valid[gi] && fu_ready[gi];
            assign fu_pkt[gi]     = mem_reg[head_reg];
            assign lane_count[gi] = count_reg;

            // Occupancy: a simultaneous enqueue and dequeue leaves the count unchanged.
            always_comb begin
                count_next = count_reg;
                case ({lane_enq[gi], lane_deq[gi]})
                    2'b10:   count_next = count_reg + CNT_W'(1);
                    2'b01:   count_next = count_reg - CNT_W'(1);
                    default: count_next = count_reg;
                endcase
            end

            // Pointer and count registers; flush rewinds the lane to empty.
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (lane_enq[gi]) begin
                        tail_reg <= tail_reg + PTR_W'(1);
                    end
                    if (lane_deq[gi]) begin
                        head_reg <= head_reg + PTR_W'(1);
                    end
                    count_reg <= count_next;
                end
            end

            // Lane storage: cleared on reset so the head reads zero afterwards;
            // flush only rewinds pointers and leaves stale data unread.
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int k = 0; k < LANE_DEPTH; k++) begin
                        mem_reg[k] <= '0;
                    end
                end else if (lane_enq[gi]) begin
                    mem_reg[tail_reg] <= in_pkt;
                end
            end
        end
    endgenerate

    // Next-state for the illegal-select pulse and the delivery counter.
    // Dequeues in a flush cycle still count since the FU has taken the packet.
    always_comb begin
        err_illegal_next    = accept && (in_fu_sel == 2'd3) && !flush;
        dispatch_total_next = dispatch_total_reg
                            + 16'(lane_deq[0])
                            + 16'(lane_deq[1])
                            + 16'(lane_deq[2]);
    end

    // Status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_illegal_reg    <= 1'b0;
            dispatch_total_reg <= '0;
        end else begin
            err_illegal_reg    <= err_illegal_next;
            dispatch_total_reg <= dispatch_total_next;
        end
    end

    assign err_illegal    = err_illegal_reg;
    assign dispatch_total = dispatch_total_reg;

endmodule

// File: tb/tb_fu_dispatch.sv
// Directed testbench for fu_dispatch with default parameters (PKT_W=64, LANE_DEPTH=2).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point too.
module tb_fu_dispatch;

    localparam int PKT_W      = 64;
    localparam int LANE_DEPTH = 2;
    localparam int CNT_W      = $clog2(LANE_DEPTH) + 1;

    logic                        clock;
    logic                        reset;
    logic                        in_valid;
    logic [1:0]                  in_fu_sel;
    logic [PKT_W-1:0]            in_pkt;
    logic                        in_ready;
    logic                        flush;
    logic [2:0]                  fu_valid;
    logic [2:0][PKT_W-1:0]       fu_pkt;
    logic [2:0]                  fu_ready;
    logic                        err_illegal;
    logic [2:0][CNT_W-1:0]       lane_count;
    logic [15:0]                 dispatch_total;

    int checks;
    int failures;

    fu_dispatch #(
        .PKT_W      (PKT_W),
        .LANE_DEPTH (LANE_DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_fu_sel      (in_fu_sel),
        .in_pkt         (in_pkt),
        .in_ready       (in_ready),
        .flush          (flush),
        .fu_valid       (fu_valid),
        .fu_pkt         (fu_pkt),
        .fu_ready       (fu_ready),
        .err_illegal    (err_illegal),
        .lane_count     (lane_count),
        .dispatch_total (dispatch_total)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one packet for one cycle, then drop in_valid.
    task automatic enqueue(input logic [1:0] sel, input logic [PKT_W-1:0] pkt);
        in_valid  = 1'b1;
        in_fu_sel = sel;
        in_pkt    = pkt;
        step();
        in_valid  = 1'b0;
        $display("txn enq sel=%0d pkt=%h counts=%0d/%0d/%0d", sel, pkt,
                 lane_count[0], lane_count[1], lane_count[2]);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_fu_sel = 2'd0;
        in_pkt    = 64'h1234;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready got=%b exp=0", in_ready); failures++;
        end
        checks++;
        if (fu_valid !== 3'b000) begin
            $display("FAIL reset_fu_valid got=%b exp=000", fu_valid); failures++;
        end
        checks++;
        if (dispatch_total !== 16'd0 || err_illegal !== 1'b0) begin
            $display("FAIL reset_status total=%0d err=%b exp 0/0", dispatch_total, err_illegal); failures++;
        end
        checks++;
        if (fu_pkt !== '0 || lane_count !== '0) begin
            $display("FAIL reset_pkt_count pkt=%h cnt=%h exp 0", fu_pkt, lane_count); failures++;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        $display("txn reset released");
    endtask

    task automatic test_basic();
        in_valid  = 1'b1;
        in_fu_sel = 2'd1;
        in_pkt    = 64'hA5;
        fu_ready  = 3'b000;
        #1;
        checks++;
        if (fu_valid !== 3'b000) begin
            $display("FAIL basic_no_bypass got=%b exp=000", fu_valid); failures++;
        end
        step();
        in_valid = 1'b0;
        $display("txn enq sel=1 pkt=a5");
        checks++;
        if (fu_valid !== 3'b010) begin
            $display("FAIL basic_fu_valid got=%b exp=010", fu_valid); failures++;
        end
        checks++;
        if (fu_pkt[1] !== 64'hA5 || lane_count[1] !== CNT_W'(1)) begin
            $display("FAIL basic_head pkt=%h cnt=%0d exp a5/1", fu_pkt[1], lane_count[1]); failures++;
        end
        fu_ready = 3'b010;
        step();
        fu_ready = 3'b000;
        $display("txn deq lane=1");
        checks++;
        if (fu_valid !== 3'b000 || dispatch_total !== 16'd1) begin
            $display("FAIL basic_drain valid=%b total=%0d exp 000/1", fu_valid, dispatch_total); failures++;
        end
    endtask

    task automatic test_full_lane();
        enqueue(2'd0, 64'h11);
        enqueue(2'd0, 64'h22);
        in_fu_sel = 2'd0;
        fu_ready  = 3'b001;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL full_ready_sel0 got=%b exp=0", in_ready); failures++;
        end
        fu_ready  = 3'b000;
        in_fu_sel = 2'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL full_ready_sel2 got=%b exp=1", in_ready); failures++;
        end
        fu_ready = 3'b001;
        #1;
        checks++;
        if (fu_pkt[0] !== 64'h11) begin
            $display("FAIL full_first got=%h exp=11", fu_pkt[0]); failures++;
        end
        step();
        $display("txn deq lane=0");
        checks++;
        if (fu_pkt[0] !== 64'h22 || lane_count[0] !== CNT_W'(1)) begin
            $display("FAIL full_second pkt=%h cnt=%0d exp 22/1", fu_pkt[0], lane_count[0]); failures++;
        end
        step();
        fu_ready = 3'b000;
        $display("txn deq lane=0");
        checks++;
        if (fu_valid[0] !== 1'b0 || dispatch_total !== 16'd3) begin
            $display("FAIL full_drain valid0=%b total=%0d exp 0/3", fu_valid[0], dispatch_total); failures++;
        end
    endtask

    task automatic test_concurrent();
        enqueue(2'd0, 64'h44);
        in_valid  = 1'b1;
        in_fu_sel = 2'd0;
        in_pkt    = 64'h33;
        fu_ready  = 3'b001;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL conc_ready got=%b exp=1", in_ready); failures++;
        end
        step();
        in_valid = 1'b0;
        fu_ready = 3'b000;
        $display("txn enq+deq lane=0 pkt=33");
        checks++;
        if (lane_count[0] !== CNT_W'(1) || fu_pkt[0] !== 64'h33) begin
            $display("FAIL conc_head cnt=%0d pkt=%h exp 1/33", lane_count[0], fu_pkt[0]); failures++;
        end
        checks++;
        if (dispatch_total !== 16'd4) begin
            $display("FAIL conc_total got=%0d exp=4", dispatch_total); failures++;
        end
        fu_ready = 3'b001;
        step();
        fu_ready = 3'b000;
        $display("txn deq lane=0");
    endtask

    task automatic test_illegal();
        in_valid  = 1'b1;
        in_fu_sel = 2'd3;
        in_pkt    = 64'hDEAD;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL illegal_ready got=%b exp=1", in_ready); failures++;
        end
        step();
        in_valid = 1'b0;
        $display("txn enq sel=3 pkt=dead");
        checks++;
        if (err_illegal !== 1'b1) begin
            $display("FAIL illegal_pulse got=%b exp=1", err_illegal); failures++;
        end
        checks++;
        if (lane_count !== '0 || fu_valid !== 3'b000) begin
            $display("FAIL illegal_counts cnt=%h valid=%b exp 0", lane_count, fu_valid); failures++;
        end
        step();
        checks++;
        if (err_illegal !== 1'b0) begin
            $display("FAIL illegal_one_cycle got=%b exp=0", err_illegal); failures++;
        end
    endtask

    task automatic test_multi_dequeue();
        enqueue(2'd0, 64'hA0);
        enqueue(2'd1, 64'hA1);
        enqueue(2'd2, 64'hA2);
        fu_ready = 3'b111;
        step();
        $display("txn deq lanes=111");
        checks++;
        if (dispatch_total !== 16'd8 || fu_valid !== 3'b000) begin
            $display("FAIL multi_deq total=%0d valid=%b exp 8/000", dispatch_total, fu_valid); failures++;
        end
        step();
        fu_ready = 3'b000;
        checks++;
        if (dispatch_total !== 16'd8) begin
            $display("FAIL empty_ready total=%0d exp=8", dispatch_total); failures++;
        end
    endtask

    task automatic test_flush();
        enqueue(2'd0, 64'h51);
        enqueue(2'd0, 64'h52);
        enqueue(2'd1, 64'h61);
        enqueue(2'd2, 64'h71);
        checks++;
        if (lane_count[0] !== CNT_W'(2) || lane_count[1] !== CNT_W'(1) || lane_count[2] !== CNT_W'(1)) begin
            $display("FAIL flush_setup cnt=%h exp 2/1/1", lane_count); failures++;
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_fu_sel = 2'd1;
        in_pkt    = 64'h99;
        fu_ready  = 3'b001;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL flush_ready got=%b exp=0", in_ready); failures++;
        end
        step();
        $display("txn flush");
        checks++;
        if (fu_valid !== 3'b000 || lane_count !== '0) begin
            $display("FAIL flush_empty valid=%b cnt=%h exp 0", fu_valid, lane_count); failures++;
        end
        checks++;
        if (dispatch_total !== 16'd9) begin
            $display("FAIL flush_total got=%0d exp=9", dispatch_total); failures++;
        end
        in_fu_sel = 2'd3;
        fu_ready  = 3'b000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        $display("txn flush sel=3");
        checks++;
        if (err_illegal !== 1'b0) begin
            $display("FAIL flush_err_suppress got=%b exp=0", err_illegal); failures++;
        end
        enqueue(2'd0, 64'h77);
        checks++;
        if (fu_pkt[0] !== 64'h77 || lane_count[0] !== CNT_W'(1)) begin
            $display("FAIL flush_ptr_rewind pkt=%h cnt=%0d exp 77/1", fu_pkt[0], lane_count[0]); failures++;
        end
    endtask

    task automatic test_reset_mid();
        enqueue(2'd2, 64'h88);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_fu_sel = 2'd1;
        in_pkt    = 64'hBB;
        fu_ready  = 3'b100;
        step();
        $display("txn reset mid-operation");
        checks++;
        if (fu_valid !== 3'b000 || dispatch_total !== 16'd0) begin
            $display("FAIL midreset_status valid=%b total=%0d exp 000/0", fu_valid, dispatch_total); failures++;
        end
        checks++;
        if (fu_pkt !== '0 || lane_count !== '0) begin
            $display("FAIL midreset_pkt pkt=%h cnt=%h exp 0", fu_pkt, lane_count); failures++;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        fu_ready = 3'b000;
        step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_fu_sel = 2'd0;
        in_pkt    = '0;
        flush     = 1'b0;
        fu_ready  = 3'b000;
        test_reset();
        test_basic();
        test_full_lane();
        test_concurrent();
        test_illegal();
        test_multi_dequeue();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
